muldiv_control_unit: RTL and testbench

//   Hardwired control sequencer driving the datapath control inputs for fetch and MUL/DIV execution.
//   It is the issuing end of the datapath control interface and generates the cycle-by-cycle strobes.

---
 rtl/cpu_ctrl_pkg.sv | 35 +++
 rtl/reg_select_4to16.sv | 15 +
 rtl/muldiv_control_unit.sv | 159 +++++++++++++++
 tb/tb_muldiv_control_unit.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared control-sequencer types: state encoding,
// opcode constants and IR field positions.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE,
    T0,
    T1,
    T2,
    T3,
    T4,
    T4W,
    T5,
    T6,
    ILLEGAL
  } state_t;

  localparam logic [4:0] OP_MUL = 5'b01111;
  localparam logic [4:0] OP_DIV = 5'b10000;
  localparam logic [4:0] OP_ADD = 5'b00011;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 27;
  localparam int RB_HI  = 22;
  localparam int RB_LO  = 19;
  localparam int RC_HI  = 18;
  localparam int RC_LO  = 15;

  function automatic logic is_muldiv(
    input logic [4:0] op
  );
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/reg_select_4to16.sv
// Register bus-enable decoder: 4-bit index to
// 16-bit one-hot, all zero when disabled.
module reg_select_4to16 (
  input  logic [3:0]  idx,
  input  logic        en,
  output logic [15:0] onehot
);

  // one-hot decode gated by enable
  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/muldiv_control_unit.sv
// Hardwired fetch + MUL/DIV sequencer issuing
// datapath strobes from a registered state.
module muldiv_control_unit
  import cpu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        run,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  input  logic        alu_done,
  output logic        PCout,
  output logic        MARin,
  output logic        IncPC,
  output logic        PCin,
  output logic        MDRread,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        ZLOin,
  output logic        ZHIin,
  output logic        ZLOout,
  output logic        ZHIout,
  output logic        LOin,
  output logic        HIin,
  output logic [15:0] Rout,
  output logic [15:0] Rin,
  output logic [4:0]  ALU_opcode,
  output logic        alu_start,
  output logic        illegal_op,
  output logic        busy
);

  state_t     state;
  state_t     state_nx;
  logic [4:0] op_q;
  logic [3:0] rb_q;
  logic [3:0] rc_q;
  logic       legal;
  logic       sel_en;
  logic [3:0] sel_idx;
  logic       unused_ir;

  assign unused_ir = ^{ir[26:23], ir[14:0]};
  assign legal     = is_muldiv(op_q);

  // state register; IR fields captured leaving T2
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      op_q  <= '0;
      rb_q  <= '0;
      rc_q  <= '0;
    end else begin
      state <= state_nx;
      if (state == T2) begin
        op_q <= ir[OPC_HI:OPC_LO];
        rb_q <= ir[RB_HI:RB_LO];
        rc_q <= ir[RC_HI:RC_LO];
      end
    end
  end

  // next-state sequencing with memory/ALU holds
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (run) state_nx = T0;
      T0:      state_nx = T1;
      T1:      if (mem_ready) state_nx = T2;
      T2:      state_nx = T3;
      T3:      state_nx = legal ? T4 : ILLEGAL;
      T4:      state_nx = T4W;
      T4W:     if (alu_done) state_nx = T5;
      T5:      state_nx = T6;
      T6:      state_nx = run ? T0 : IDLE;
      ILLEGAL: state_nx = ILLEGAL;
      default: state_nx = IDLE;
    endcase
  end

  // Rb drives the bus in T3, Rc through T4/T4W
  assign sel_en  = ((state == T3) && legal) ||
                   (state == T4) || (state == T4W);
  assign sel_idx = (state == T3) ? rb_q : rc_q;

  reg_select_4to16 u_rsel (
    .idx    (sel_idx),
    .en     (sel_en),
    .onehot (Rout)
  );

  assign Rin  = '0;
  assign busy = (state != IDLE);

  // strobe decode; PCin and Z capture gated
  // by the handshake in their exit cycle
  always_comb begin
    PCout      = 1'b0;
    MARin      = 1'b0;
    IncPC      = 1'b0;
    PCin       = 1'b0;
    MDRread    = 1'b0;
    MDRin      = 1'b0;
    MDRout     = 1'b0;
    IRin       = 1'b0;
    Yin        = 1'b0;
    ZLOin      = 1'b0;
    ZHIin      = 1'b0;
    ZLOout     = 1'b0;
    ZHIout     = 1'b0;
    LOin       = 1'b0;
    HIin       = 1'b0;
    ALU_opcode = '0;
    alu_start  = 1'b0;
    illegal_op = 1'b0;
    unique case (state)
      T0: begin
        PCout      = 1'b1;
        MARin      = 1'b1;
        IncPC      = 1'b1;
        ZLOin      = 1'b1;
        ALU_opcode = OP_ADD;
      end
      T1: begin
        ZLOout  = 1'b1;
        MDRread = 1'b1;
        MDRin   = 1'b1;
        PCin    = mem_ready;
      end
      T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      T3: Yin = legal;
      T4: begin
        ALU_opcode = op_q;
        alu_start  = 1'b1;
      end
      T4W: begin
        ALU_opcode = op_q;
        ZLOin      = alu_done;
        ZHIin      = alu_done;
      end
      T5: begin
        ZLOout = 1'b1;
        LOin   = 1'b1;
      end
      T6: begin
        ZHIout = 1'b1;
        HIin   = 1'b1;
      end
      ILLEGAL: illegal_op = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_muldiv_control_unit.sv
// Self-checking bench: expected per-cycle strobe
// traces built from instruction-level timing plans.
module tb_muldiv_control_unit;

  logic        clk = 1'b0;
  logic        clr, run, mem_ready, alu_done;
  logic [31:0] ir;
  logic PCout, MARin, IncPC, PCin, MDRread, MDRin;
  logic MDRout, IRin, Yin, ZLOin, ZHIin, ZLOout;
  logic ZHIout, LOin, HIin, alu_start, illegal_op;
  logic busy;
  logic [15:0] Rout, Rin;
  logic [4:0]  ALU_opcode;

  int nchk = 0;
  int nerr = 0;

  localparam logic [14:0] S_PCOUT  = 15'h4000;
  localparam logic [14:0] S_MARIN  = 15'h2000;
  localparam logic [14:0] S_INCPC  = 15'h1000;
  localparam logic [14:0] S_PCIN   = 15'h0800;
  localparam logic [14:0] S_MDRRD  = 15'h0400;
  localparam logic [14:0] S_MDRIN  = 15'h0200;
  localparam logic [14:0] S_MDROUT = 15'h0100;
  localparam logic [14:0] S_IRIN   = 15'h0080;
  localparam logic [14:0] S_YIN    = 15'h0040;
  localparam logic [14:0] S_ZLOIN  = 15'h0020;
  localparam logic [14:0] S_ZHIIN  = 15'h0010;
  localparam logic [14:0] S_ZLOOUT = 15'h0008;
  localparam logic [14:0] S_ZHIOUT = 15'h0004;
  localparam logic [14:0] S_LOIN   = 15'h0002;
  localparam logic [14:0] S_HIIN   = 15'h0001;

  typedef struct {
    logic        clr;
    logic        run;
    logic        mr;
    logic        ad;
    logic [31:0] ir;
    logic [54:0] exp;
  } step_t;

  step_t q[$];

  muldiv_control_unit dut (
    .clk        (clk),
    .clr        (clr),
    .run        (run),
    .ir         (ir),
    .mem_ready  (mem_ready),
    .alu_done   (alu_done),
    .PCout      (PCout),
    .MARin      (MARin),
    .IncPC      (IncPC),
    .PCin       (PCin),
    .MDRread    (MDRread),
    .MDRin      (MDRin),
    .MDRout     (MDRout),
    .IRin       (IRin),
    .Yin        (Yin),
    .ZLOin      (ZLOin),
    .ZHIin      (ZHIin),
    .ZLOout     (ZLOout),
    .ZHIout     (ZHIout),
    .LOin       (LOin),
    .HIin       (HIin),
    .Rout       (Rout),
    .Rin        (Rin),
    .ALU_opcode (ALU_opcode),
    .alu_start  (alu_start),
    .illegal_op (illegal_op),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [54:0] ev(
    input logic [14:0] s,
    input logic        st,
    input logic        il,
    input logic        by,
    input logic [4:0]  alu,
    input logic [15:0] ro
  );
    return {s, st, il, by, alu, ro, 16'h0};
  endfunction

  function automatic logic [15:0] oh(input logic [3:0] i);
    logic [15:0] one;
    one = 16'h1;
    return one << i;
  endfunction

  function automatic logic [31:0] mk_ir(
    input logic [4:0] op,
    input logic [3:0] rb,
    input logic [3:0] rc
  );
    logic [3:0] junk;
    junk = 4'($urandom);
    return {op, junk, rb, rc, 15'($urandom)};
  endfunction

  task automatic add(
    input logic        c,
    input logic        r,
    input logic        mr,
    input logic        ad,
    input logic [31:0] i,
    input logic [54:0] e
  );
    step_t s;
    s.clr = c; s.run = r; s.mr = mr;
    s.ad = ad; s.ir = i; s.exp = e;
    q.push_back(s);
  endtask

  task automatic add_idle(input logic r, input logic [31:0] i);
    add(1'b0, r, 1'($urandom), 1'($urandom), i, '0);
  endtask

  // fetch through T3: w memory wait cycles in T1
  task automatic add_front(input logic [31:0] i, input int w);
    logic [4:0]  op;
    logic [3:0]  rb;
    logic        ok;
    op = i[31:27];
    rb = i[22:19];
    ok = (op == 5'b01111) || (op == 5'b10000);
    add(1'b0, 1'b1, 1'($urandom), 1'($urandom), i,
        ev(S_PCOUT | S_MARIN | S_INCPC | S_ZLOIN,
           1'b0, 1'b0, 1'b1, 5'b00011, '0));
    for (int k = 0; k < w; k++)
      add(1'b0, 1'b1, 1'b0, 1'($urandom), i,
          ev(S_ZLOOUT | S_MDRRD | S_MDRIN,
             1'b0, 1'b0, 1'b1, '0, '0));
    add(1'b0, 1'b1, 1'b1, 1'($urandom), i,
        ev(S_ZLOOUT | S_MDRRD | S_MDRIN | S_PCIN,
           1'b0, 1'b0, 1'b1, '0, '0));
    add(1'b0, 1'b1, 1'($urandom), 1'($urandom), i,
        ev(S_MDROUT | S_IRIN, 1'b0, 1'b0, 1'b1, '0, '0));
    if (ok)
      add(1'b0, 1'b1, 1'($urandom), 1'($urandom), i,
          ev(S_YIN, 1'b0, 1'b0, 1'b1, '0, oh(rb)));
    else
      add(1'b0, 1'b1, 1'($urandom), 1'($urandom), i,
          ev('0, 1'b0, 1'b0, 1'b1, '0, '0));
  endtask

  // execute: alu_done arrives L cycles after alu_start
  task automatic add_back(
    input logic [31:0] i,
    input int          L,
    input logic        rt
  );
    logic [4:0] op;
    logic [3:0] rc;
    op = i[31:27];
    rc = i[18:15];
    add(1'b0, rt, 1'($urandom), 1'($urandom), i,
        ev('0, 1'b1, 1'b0, 1'b1, op, oh(rc)));
    for (int k = 1; k < L; k++)
      add(1'b0, rt, 1'($urandom), 1'b0, i,
          ev('0, 1'b0, 1'b0, 1'b1, op, oh(rc)));
    add(1'b0, rt, 1'($urandom), 1'b1, i,
        ev(S_ZLOIN | S_ZHIIN, 1'b0, 1'b0, 1'b1, op, oh(rc)));
    add(1'b0, rt, 1'($urandom), 1'($urandom), i,
        ev(S_ZLOOUT | S_LOIN, 1'b0, 1'b0, 1'b1, '0, '0));
    add(1'b0, rt, 1'($urandom), 1'($urandom), i,
        ev(S_ZHIOUT | S_HIIN, 1'b0, 1'b0, 1'b1, '0, '0));
  endtask

  task automatic play(input string name);
    int n;
    n = 0;
    while (q.size() > 0) begin
      step_t s;
      logic [54:0] got;
      s = q.pop_front();
      @(negedge clk);
      clr = s.clr; run = s.run; ir = s.ir;
      mem_ready = s.mr; alu_done = s.ad;
      #1;
      got = {PCout, MARin, IncPC, PCin, MDRread,
             MDRin, MDRout, IRin, Yin, ZLOin, ZHIin,
             ZLOout, ZHIout, LOin, HIin, alu_start,
             illegal_op, busy, ALU_opcode, Rout, Rin};
      nchk++;
      if (got !== s.exp) begin
        nerr++;
        $display("FAIL %s cyc %0d: got %h exp %h",
                 name, n, got, s.exp);
      end
      nchk++;
      if ($countones({PCout, MDRout, ZLOout,
                      ZHIout, Rout}) > 1) begin
        nerr++;
        $display("FAIL %s_bus cyc %0d: got %0d drivers exp <=1",
                 name, n, $countones({PCout, MDRout,
                 ZLOout, ZHIout, Rout}));
      end
      n++;
    end
  endtask

  task automatic test_reset();
    clr = 1'b1; run = 1'b1; ir = '0;
    mem_ready = 1'b0; alu_done = 1'b0;
    @(posedge clk);
    add(1'b1, 1'b1, 1'b1, 1'b1, '0, '0);
    add(1'b1, 1'b1, 1'b1, 1'b1, '0, '0);
    add(1'b0, 1'b0, 1'b1, 1'b1, '0, '0);
    add_idle(1'b0, '0);
    play("reset");
  endtask

  task automatic test_div();
    logic [31:0] i;
    i = {5'b10000, 4'd0, 4'd6, 4'd7, 15'd0};
    add_idle(1'b1, i);
    add_front(i, 0);
    add_back(i, 3, 1'b0);
    add_idle(1'b0, i);
    add_idle(1'b0, i);
    play("div");
  endtask

  task automatic test_mul_memwait();
    logic [31:0] i;
    i = mk_ir(5'b01111, 4'($urandom), 4'($urandom));
    add_idle(1'b1, i);
    add_front(i, 4);
    add_back(i, 1 + int'($urandom_range(0, 3)), 1'b0);
    add_idle(1'b0, i);
    play("mul_memwait");
  endtask

  task automatic test_min_latency();
    logic [31:0] i;
    i = mk_ir(5'b01111, 4'($urandom), 4'($urandom));
    add_idle(1'b1, i);
    add_front(i, 0);
    add_back(i, 1, 1'b0);
    add_idle(1'b0, i);
    play("min_latency");
  endtask

  task automatic test_illegal();
    logic [31:0] i;
    i = mk_ir(5'b11111, 4'($urandom), 4'($urandom));
    add_idle(1'b1, i);
    add_front(i, 1);
    for (int k = 0; k < 5; k++)
      add(1'b0, 1'b1, 1'($urandom), 1'($urandom), i,
          ev('0, 1'b0, 1'b1, 1'b1, '0, '0));
    add(1'b1, 1'b1, 1'b1, 1'b1, i,
        ev('0, 1'b0, 1'b1, 1'b1, '0, '0));
    add(1'b0, 1'b0, 1'b1, 1'b1, i, '0);
    add_idle(1'b0, i);
    play("illegal");
  endtask

  task automatic test_clr_t4w();
    logic [31:0] i;
    logic [4:0]  op;
    logic [3:0]  rc;
    op = 5'b10000;
    i = mk_ir(op, 4'($urandom), 4'($urandom));
    rc = i[18:15];
    add_idle(1'b1, i);
    add_front(i, 2);
    add(1'b0, 1'b1, 1'b0, 1'b0, i,
        ev('0, 1'b1, 1'b0, 1'b1, op, oh(rc)));
    add(1'b0, 1'b1, 1'b0, 1'b0, i,
        ev('0, 1'b0, 1'b0, 1'b1, op, oh(rc)));
    add(1'b1, 1'b1, 1'b0, 1'b0, i,
        ev('0, 1'b0, 1'b0, 1'b1, op, oh(rc)));
    for (int k = 0; k < 4; k++)
      add(1'b0, 1'b0, 1'b1, 1'b1, i, '0);
    play("clr_t4w");
  endtask

  task automatic test_back_to_back();
    logic [31:0] i;
    logic [4:0]  op;
    add_idle(1'b1, '0);
    for (int k = 0; k < 6; k++) begin
      op = ($urandom_range(0, 1) == 0) ? 5'b01111
                                       : 5'b10000;
      i = mk_ir(op, 4'($urandom), 4'($urandom));
      add_front(i, int'($urandom_range(0, 3)));
      add_back(i, 1 + int'($urandom_range(0, 4)),
               (k != 5));
    end
    add_idle(1'b0, '0);
    add_idle(1'b0, '0);
    play("back_to_back");
  endtask

  initial begin
    test_reset();
    test_div();
    test_mul_memwait();
    test_min_latency();
    test_illegal();
    test_clr_t4w();
    test_back_to_back();
    test_mul_memwait();
    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nerr);
    $finish;
  end

endmodule
